// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the SPI arbiter slice.
// Contents: default parameter values and the arbiter FSM state encoding.
package spi_arbiter_pkg;

  localparam int DEF_BITS = 16;  // frame width, matches the attached SPIMaster
  localparam int DEF_TMO  = 64;  // cycles allowed from spi_start until spi_working rises
  localparam int DEF_GAPN = 2;   // idle cycles enforced between transactions

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

endpackage

// File: rtl/spi_arbiter_if.sv
// Bundle of requester handshakes plus the SPIMaster-facing bus.
// slave  : arbiter side (takes requests, drives acks/dones/rx and the SPIMaster controls)
// master : requester / SPIMaster side (drives requests, tx words and SPIMaster status)
interface spi_arbiter_if #(
  parameter int BITS = 16
);
  logic            req0, req1;
  logic [BITS-1:0] tx0, tx1;
  logic            ack0, ack1;
  logic            done0, done1;
  logic [BITS-1:0] rx0, rx1;
  logic            spi_start;
  logic [BITS-1:0] spi_dataOut;
  logic [BITS-1:0] spi_dataIn;
  logic            spi_working;
  logic            sel;
  logic            err;

  modport slave (
    input  req0, req1, tx0, tx1, spi_dataIn, spi_working,
    output ack0, ack1, done0, done1, rx0, rx1, spi_start, spi_dataOut, sel, err
  );

  modport master (
    output req0, req1, tx0, tx1, spi_dataIn, spi_working,
    input  ack0, ack1, done0, done1, rx0, rx1, spi_start, spi_dataOut, sel, err
  );
endinterface

// File: rtl/spi_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-served register.
// Ports: i_clk, i_rst_n (async, active-low), i_srst (sync soft reset),
//        i_req0/i_req1 requests, i_take (grant consumed this cycle),
//        o_valid (some request present), o_grant (index of winner).
module spi_rr_arb2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_srst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_take,
  output logic o_valid,
  output logic o_grant
);
  logic r_last;

  // Winner selection: contested requests go to the one not served last.
  always_comb begin
    o_valid = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_grant = ~r_last;
    end else if (i_req1) begin
      o_grant = 1'b1;
    end else begin
      o_grant = 1'b0;
    end
  end

  // Last-served register; resets to 1 so requester 0 wins the first contest.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'b1;
    end else if (i_srst) begin
      r_last <= 1'b1;
    end else if (i_take) begin
      r_last <= o_grant;
    end else begin
      r_last <= r_last;
    end
  end
endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPIMaster between two requesters with round-robin arbitration,
// a start timeout and an enforced idle gap between transactions.
// Ports: i_clk, i_rst_n (async, active-low), i_srst (sync soft reset),
//        bus (spi_arbiter_if.slave): requester handshakes and SPIMaster bus.
// All outputs are registered.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int TMO  = DEF_TMO,
  parameter int GAPN = DEF_GAPN
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_srst,
  spi_arbiter_if.slave  bus
);
  localparam int CNT_MAX = (TMO > GAPN) ? TMO : GAPN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t          r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic            r_ack0, r_ack1, r_done0, r_done1, r_start, r_err, r_sel;
  logic            w_ack0_nxt, w_ack1_nxt, w_done0_nxt, w_done1_nxt;
  logic            w_start_nxt, w_err_nxt, w_sel_nxt;
  logic [BITS-1:0] r_dout, w_dout_nxt;
  logic [BITS-1:0] r_rx0, r_rx1;
  logic            w_cap0, w_cap1;
  logic            w_take, w_valid, w_grant;

  spi_rr_arb2 u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_srst  (i_srst),
    .i_req0  (bus.req0),
    .i_req1  (bus.req1),
    .i_take  (w_take),
    .o_valid (w_valid),
    .o_grant (w_grant)
  );

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    w_done0_nxt = 1'b0;
    w_done1_nxt = 1'b0;
    w_start_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_sel_nxt   = r_sel;
    w_dout_nxt  = r_dout;
    w_cap0      = 1'b0;
    w_cap1      = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_take      = 1'b1;
          w_sel_nxt   = w_grant;
          w_dout_nxt  = w_grant ? bus.tx1 : bus.tx0;
          w_ack0_nxt  = ~w_grant;
          w_ack1_nxt  = w_grant;
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        w_start_nxt = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (bus.spi_working) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_cnt == CNT_W'(TMO - 1)) begin
          // Timeout still closes the transaction so the requester is released.
          w_err_nxt   = 1'b1;
          w_done0_nxt = ~r_sel;
          w_done1_nxt = r_sel;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_GAP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.spi_working) begin
          w_cap0      = ~r_sel;
          w_cap1      = r_sel;
          w_done0_nxt = ~r_sel;
          w_done1_nxt = r_sel;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      ST_GAP: begin
        // GAPN == 0 still spends one cycle here.
        if ((GAPN == 0) || (r_cnt == CNT_W'(GAPN - 1))) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, counter and registered control outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
      r_sel   <= 1'b0;
      r_dout  <= '0;
    end else if (i_srst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
      r_sel   <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_done0 <= w_done0_nxt;
      r_done1 <= w_done1_nxt;
      r_start <= w_start_nxt;
      r_err   <= w_err_nxt;
      r_sel   <= w_sel_nxt;
      r_dout  <= w_dout_nxt;
    end
  end

  // Per-requester receive capture, held until that requester's next done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx0 <= '0;
      r_rx1 <= '0;
    end else if (i_srst) begin
      r_rx0 <= '0;
      r_rx1 <= '0;
    end else begin
      r_rx0 <= w_cap0 ? bus.spi_dataIn : r_rx0;
      r_rx1 <= w_cap1 ? bus.spi_dataIn : r_rx1;
    end
  end

  assign bus.ack0        = r_ack0;
  assign bus.ack1        = r_ack1;
  assign bus.done0       = r_done0;
  assign bus.done1       = r_done1;
  assign bus.spi_start   = r_start;
  assign bus.err         = r_err;
  assign bus.sel         = r_sel;
  assign bus.spi_dataOut = r_dout;
  assign bus.rx0         = r_rx0;
  assign bus.rx1         = r_rx1;
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a behavioural SPIMaster that answers
// each frame with (tx + 16'h4444), a requester driver and a scoreboard.
module tb_spi_arbiter;
  localparam int BITS = 16;
  localparam int TMO  = 20;
  localparam int GAPN = 2;

  typedef struct {
    int            id;
    logic [BITS-1:0] word;
    logic          e;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic srst  = 1'b0;
  always #5 clk = ~clk;

  spi_arbiter_if #(.BITS(BITS)) bus ();

  spi_arbiter #(.BITS(BITS), .TMO(TMO), .GAPN(GAPN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_srst  (srst),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  exp_t ackq[$];
  exp_t doneq[$];
  int n_ack = 0, n_start = 0, n_err = 0;
  int ack_cyc[2];
  int done_cyc[2];
  int start_cyc = 0, err_cyc = 0;
  int more0 = 0, more1 = 0;
  logic slave_en = 1'b1;
  int busy_len = 4;
  int busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(int id, logic [BITS-1:0] w, logic e);
    exp_t x;
    x.id = id; x.word = w; x.e = e;
    return x;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(string tag, int budget);
    int n = 0;
    while (doneq.size() > 0 && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_drained"}, doneq.size(), 0);
    tick(GAPN + 2);
  endtask

  // SPIMaster model: busy for busy_len cycles after spi_start, then returns tx+0x4444.
  initial begin
    bus.spi_working = 1'b0;
    bus.spi_dataIn  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.spi_working = 1'b0;
        busy = 0;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          bus.spi_dataIn  = bus.spi_dataOut + 16'h4444;
          bus.spi_working = 1'b0;
        end
      end else if (bus.spi_start && slave_en) begin
        bus.spi_working = 1'b1;
        busy = busy_len;
      end
    end
  end

  // Requester driver: on ack either drop req or present the next word.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.ack0) begin
        if (more0 > 0) begin more0--; bus.tx0 = bus.tx0 + 16'h0001; end
        else bus.req0 = 1'b0;
      end
      if (bus.ack1) begin
        if (more1 > 0) begin more1--; bus.tx1 = bus.tx1 + 16'h0001; end
        else bus.req1 = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    int id;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.ack0 || bus.ack1) begin
          n_ack++;
          id = bus.ack1 ? 1 : 0;
          ack_cyc[id] = cyc;
          check("ack_expected", 32'(ackq.size() > 0), 1);
          check("ack_onehot", 32'(bus.ack0 & bus.ack1), 0);
          if (ackq.size() > 0) begin
            e = ackq.pop_front();
            check("ack_id", id, e.id);
            check("ack_sel", 32'(bus.sel), e.id);
            check("ack_dataOut", 32'(bus.spi_dataOut), 32'(e.word));
          end
        end
        if (bus.spi_start) begin
          n_start++;
          start_cyc = cyc;
          check("start_latency", cyc - ack_cyc[bus.sel], 1);
        end
        if (bus.err) begin
          n_err++;
          err_cyc = cyc;
          check("err_has_done", 32'(bus.done0 | bus.done1), 1);
        end
        if (bus.done0 || bus.done1) begin
          id = bus.done1 ? 1 : 0;
          done_cyc[id] = cyc;
          check("done_expected", 32'(doneq.size() > 0), 1);
          if (doneq.size() > 0) begin
            e = doneq.pop_front();
            check("done_id", id, e.id);
            check("done_rx", 32'(id ? bus.rx1 : bus.rx0), 32'(e.word));
            check("done_err", 32'(bus.err), 32'(e.e));
          end
        end
      end
    end
  end

  initial begin
    int s_ack, s_start, n;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.tx0 = '0;    bus.tx1 = '0;

    // Reset state
    tick(3);
    check("rst_ack0", 32'(bus.ack0), 0);
    check("rst_ack1", 32'(bus.ack1), 0);
    check("rst_done0", 32'(bus.done0), 0);
    check("rst_done1", 32'(bus.done1), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_start", 32'(bus.spi_start), 0);
    check("rst_sel", 32'(bus.sel), 0);
    check("rst_dataOut", 32'(bus.spi_dataOut), 0);
    check("rst_rx0", 32'(bus.rx0), 0);
    check("rst_rx1", 32'(bus.rx1), 0);
    rst_n = 1'b1;
    tick(2);

    // Single request with loopback
    ackq.push_back(mk(0, 16'h1234, 1'b0));
    doneq.push_back(mk(0, 16'h5678, 1'b0));
    bus.tx0 = 16'h1234; more0 = 0; bus.req0 = 1'b1;
    drain("single", 100);
    check("single_rx0", 32'(bus.rx0), 32'h5678);
    check("single_sel", 32'(bus.sel), 0);

    // Simultaneous first requests after reset: 0 then 1, gap GAPN+1
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(2);
    ackq.push_back(mk(0, 16'hA000, 1'b0));
    ackq.push_back(mk(1, 16'hB000, 1'b0));
    doneq.push_back(mk(0, 16'hE444, 1'b0));
    doneq.push_back(mk(1, 16'hF444, 1'b0));
    bus.tx0 = 16'hA000; bus.tx1 = 16'hB000;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    drain("simul", 200);
    check("simul_gap", ack_cyc[1] - done_cyc[0], GAPN + 1);

    // Both held for four transactions: 0,1,0,1
    ackq.push_back(mk(0, 16'h1000, 1'b0));
    ackq.push_back(mk(1, 16'h2000, 1'b0));
    ackq.push_back(mk(0, 16'h1001, 1'b0));
    ackq.push_back(mk(1, 16'h2001, 1'b0));
    doneq.push_back(mk(0, 16'h5444, 1'b0));
    doneq.push_back(mk(1, 16'h6444, 1'b0));
    doneq.push_back(mk(0, 16'h5445, 1'b0));
    doneq.push_back(mk(1, 16'h6445, 1'b0));
    bus.tx0 = 16'h1000; bus.tx1 = 16'h2000; more0 = 1; more1 = 1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    drain("rr4", 400);
    check("rr4_rx0", 32'(bus.rx0), 32'h5445);
    check("rr4_rx1", 32'(bus.rx1), 32'h6445);

    // req1 pulsed during GAP and dropped: no grant
    ackq.push_back(mk(0, 16'h0042, 1'b0));
    doneq.push_back(mk(0, 16'h4486, 1'b0));
    bus.tx0 = 16'h0042; bus.req0 = 1'b1;
    n = 0;
    while (!bus.done0 && n < 100) begin tick(1); n++; end
    check("pulse_done0_seen", 32'(bus.done0), 1);
    s_ack = n_ack; s_start = n_start;
    bus.tx1 = 16'h0777; bus.req1 = 1'b1;
    tick(1);
    bus.req1 = 1'b0;
    tick(10);
    check("pulse_no_ack", n_ack, s_ack);
    check("pulse_no_start", n_start, s_start);
    check("pulse_q_empty", doneq.size(), 0);

    // Timeout: SPIMaster never starts
    slave_en = 1'b0;
    ackq.push_back(mk(1, 16'h0BAD, 1'b0));
    doneq.push_back(mk(1, 16'h6445, 1'b1));
    bus.tx1 = 16'h0BAD; bus.req1 = 1'b1;
    drain("tmo", 200);
    check("tmo_latency", err_cyc - start_cyc, TMO);
    check("tmo_err_count", n_err, 1);
    check("tmo_rx1_held", 32'(bus.rx1), 32'h6445);
    slave_en = 1'b1;

    // Reset during WAIT_DONE
    busy_len = 30;
    ackq.push_back(mk(0, 16'h0301, 1'b0));
    bus.tx0 = 16'h0301; bus.req0 = 1'b1;
    s_start = n_start; n = 0;
    while (n_start == s_start && n < 100) begin tick(1); n++; end
    check("midrst_started", n_start, s_start + 1);
    tick(5);
    rst_n = 1'b0;
    #1;
    check("midrst_ack0", 32'(bus.ack0), 0);
    check("midrst_done0", 32'(bus.done0), 0);
    check("midrst_err", 32'(bus.err), 0);
    check("midrst_start", 32'(bus.spi_start), 0);
    check("midrst_sel", 32'(bus.sel), 0);
    check("midrst_dataOut", 32'(bus.spi_dataOut), 0);
    check("midrst_rx0", 32'(bus.rx0), 0);
    check("midrst_rx1", 32'(bus.rx1), 0);
    tick(3);
    busy_len = 4;
    rst_n = 1'b1;
    tick(2);
    ackq.push_back(mk(0, 16'h0401, 1'b0));
    ackq.push_back(mk(1, 16'h0402, 1'b0));
    doneq.push_back(mk(0, 16'h4845, 1'b0));
    doneq.push_back(mk(1, 16'h4846, 1'b0));
    bus.tx0 = 16'h0401; bus.tx1 = 16'h0402;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    drain("postrst", 200);
    check("postrst_order", 32'(ack_cyc[0] < ack_cyc[1]), 1);

    check("end_ackq_empty", ackq.size(), 0);
    check("end_doneq_empty", doneq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter BITS, default 16, frame width in bits; equals the attached SPIMaster BITS.
REQ-002 Parameter TMO, default 64, maximum cycles from spi_start until spi_working rises.
REQ-003 Parameter GAPN, default 2, minimum idle cycles between consecutive transactions.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low.
REQ-006 req0 / req1  in  1  requester n wants one transaction; level, held until ackn.
REQ-007 tx0 / tx1  in  BITS  requester n transmit word; valid while reqn high.
REQ-008 ack0 / ack1  out  1  one-cycle pulse: request n accepted, txn sampled this cycle.
REQ-009 done0 / done1  out  1  one-cycle pulse: transaction n finished, rxn valid.
REQ-010 rx0 / rx1  out  BITS  last received word for requester n; held until next done of n.
REQ-011 spi_start  out  1  start strobe to SPIMaster.
REQ-012 spi_dataOut  out  BITS  transmit word to SPIMaster; stable from spi_start until done.
REQ-013 spi_dataIn  in  BITS  received word from SPIMaster.
REQ-014 spi_working  in  1  SPIMaster busy flag.
REQ-015 sel  out  1  index of granted requester; steers external cs/sdi muxing; stable IDLE-exit to next grant.
REQ-016 err  out  1  one-cycle pulse: SPIMaster failed to start within TMO cycles.

Function
REQ-017 States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP; one-hot or binary encoding is free.
REQ-018 IDLE: if any req high, same cycle pulse ack of winner, latch its tx into spi_dataOut, set sel, go START.
REQ-019 Arbitration: round-robin; with both requests, grant the requester not served last; single request wins immediately.
REQ-020 After reset, last-served = 1, so req0 wins a simultaneous first request.
REQ-021 START: spi_start = 1 for exactly one cycle, clear timeout counter, go WAIT_BUSY.
REQ-022 WAIT_BUSY: spi_working = 1 -> WAIT_DONE; else increment counter; counter = TMO-1 -> err pulse, done pulse of sel, rx unchanged, go GAP.
REQ-023 WAIT_DONE: on first cycle spi_working = 0, capture spi_dataIn into rx[sel], pulse done[sel] same cycle, go GAP.
REQ-024 GAP: count GAPN cycles, then IDLE; requests arriving meanwhile wait; GAPN = 0 -> one GAP cycle.
REQ-025 Grant-to-start latency 1 cycle; done-to-next-ack latency GAPN+1 cycles minimum.
REQ-026 Requester dropping req before ack: no transaction; dropping req after ack: transaction completes normally.
REQ-027 Requester may raise req in cycle after its done; re-raising while other waits yields alternation.
REQ-028 ack, done, err, spi_start never high in the same cycle for the same requester except done/err on timeout.

Reset
REQ-029 rst low: state IDLE; spi_start, ack*, done*, err = 0; spi_dataOut, rx0, rx1 = 0; sel = 0; counters = 0; last-served = 1.
REQ-030 Reset mid-transaction aborts without done; SPIMaster reset externally alongside.

Structure
REQ-031 Shared package: state encoding typedef, default BITS/TMO/GAPN constants.
REQ-032 One sub-module natural: spi_rr_arb2 (2-way round-robin grant with last-served register).
REQ-033 Single always block for FSM state, separate registers for rx capture; no latches.

Verification
REQ-034 req0=1, tx0=16'h1234, loopback SPIMaster returns 16'h5678 -> ack0 1 cycle, spi_start next cycle, done0 with rx0=16'h5678, sel=0.
REQ-035 req0, req1 raised same cycle after reset -> req0 served first, then req1 after GAPN+1 idle cycles; ack order 0,1.
REQ-036 Both requests held continuously for 4 transactions -> grants 0,1,0,1; rx values match per-requester returned words.
REQ-037 spi_working tied 0, req1=1 -> err and done1 pulse at TMO cycles after spi_start; rx1 unchanged; back to IDLE.
REQ-038 rst asserted during WAIT_DONE -> all outputs zero immediately; no done; after release req0 wins next grant.
REQ-039 req1 pulsed then dropped before ack (during GAP) -> no ack1, no spi_start for it.
